issue_sched: RTL

- Issue/hazard controller sitting beside the decode stage.
- Tracks destination registers of in-flight long-latency ops (loads, DIV/REM) in a scoreboard and bounds outstanding ops.
- Holds fetch/decode on RAW/WAW hazards, FENCE drain or debug halt, and flushes decode on an EX jump.
- Drives the pipeline hold/flush lines and a debug halt handshake.

---
 rtl/issue_sched_pkg.sv | 32 +++
 rtl/issue_sched_scoreboard.sv | 59 +++++
 rtl/issue_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/issue_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | issue_sched_pkg : shared types and helpers for the issue scheduler        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package issue_sched_pkg;

  localparam int REG_AW          = 5;
  localparam int MAX_PENDING_DEF = 4;
  localparam int STALL_CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sched_state_e;

  // Loads and the DIV/DIVU/REM/REMU group (M-extension, funct3[2]=1).
  function automatic logic is_long_op(input logic [6:0] opcode,
                                      input logic [2:0] funct3,
                                      input logic [6:0] funct7);
    logic is_load;
    logic is_divrem;
    is_load   = (opcode == 7'b0000011);
    is_divrem = (opcode == 7'b0110011) && (funct7 == 7'b0000001) && funct3[2];
    return is_load || is_divrem;
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_sched_scoreboard.sv
// +--------------------------------------------------------------------------+
// | sched_scoreboard : pending-rd bitmap and outstanding long-op counter      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sched_scoreboard
  import issue_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_long,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       eff,
  output logic [3:0]        cnt
);

  logic [31:1] pend_q;
  logic [31:1] pend_d;
  logic [3:0]  cnt_q;
  logic        dec;

  // A same-cycle writeback hides the pending bit; a new set overrides it.
  always_comb begin
    eff    = '0;
    pend_d = '0;
    for (int r = 1; r < 32; r++) begin
      eff[r]    = pend_q[r] & ~(wb_valid && (wb_addr == REG_AW'(r)));
      pend_d[r] = eff[r] | (set_en && (set_addr == REG_AW'(r)));
    end
  end

  assign dec = wb_valid && (cnt_q != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      cnt_q  <= 4'd0;
    end else begin
      pend_q <= pend_d;
      case ({issue_long, dec})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign cnt = cnt_q;

  a_no_wb_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(wb_valid && (cnt_q == 4'd0)));

endmodule

`default_nettype wire

// File: rtl/issue_sched.sv
// +--------------------------------------------------------------------------+
// | issue_sched : decode-side hazard/issue controller with debug halt drain   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int MAX_PENDING = MAX_PENDING_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid_i,
  input  logic [REG_AW-1:0]      reg1_raddr_i,
  input  logic [REG_AW-1:0]      reg2_raddr_i,
  input  logic                   reg_we_i,
  input  logic [REG_AW-1:0]      reg_waddr_i,
  input  logic                   long_op_i,
  input  logic                   fence_i,
  input  logic                   wb_valid_i,
  input  logic [REG_AW-1:0]      wb_waddr_i,
  input  logic                   ex_jump_flag_i,
  input  logic                   halt_req_i,
  output logic                   issue_o,
  output logic                   hold_o,
  output logic                   flush_o,
  output logic                   halt_ack_o,
  output logic [3:0]             pending_cnt_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  logic [31:0]            eff;
  logic [3:0]             cnt;
  logic [3:0]             cnt_after_wb;
  logic                   raw, waw, full, drain, stall, long_issue;
  sched_state_e           state_q, state_d;
  logic                   halt_ack_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_comb begin
    raw   = eff[reg1_raddr_i] | eff[reg2_raddr_i];
    waw   = reg_we_i & eff[reg_waddr_i];
    full  = long_op_i & (cnt == 4'(MAX_PENDING)) & ~wb_valid_i;
    drain = fence_i & ((cnt - {3'b000, wb_valid_i}) != 4'd0);
    stall = id_valid_i & (raw | waw | full | drain | (state_q != RUN));
  end

  // Jump redirect beats every stall source; reset forces a hold.
  always_comb begin
    issue_o = 1'b0;
    hold_o  = 1'b1;
    flush_o = 1'b0;
    if (rst) begin
      if (ex_jump_flag_i) begin
        flush_o = 1'b1;
        hold_o  = 1'b0;
      end else begin
        hold_o  = stall;
        issue_o = id_valid_i & ~stall;
      end
    end
  end

  assign long_issue = issue_o & long_op_i;

  sched_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_long (long_issue),
    .set_en     (long_issue & reg_we_i),
    .set_addr   (reg_waddr_i),
    .wb_valid   (wb_valid_i),
    .wb_addr    (wb_waddr_i),
    .eff        (eff),
    .cnt        (cnt)
  );

  assign cnt_after_wb = (wb_valid_i && (cnt != 4'd0)) ? cnt - 4'd1 : cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!halt_req_i)                state_d = RUN;
        else if (cnt_after_wb == 4'd0)  state_d = HALTED;
      end
      HALTED:  if (!halt_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      halt_ack_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      halt_ack_q <= (state_d == HALTED);
      if (hold_o && id_valid_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign halt_ack_o    = halt_ack_q;
  assign pending_cnt_o = cnt;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

`default_nettype wire
